ram_arbiter: RTL and testbench

- Arbitrates the CPU's single-port RAM (cs/we/oe interface) between two requesters.
  - Port 0 is instruction fetch, driven by the control FSM's fetch state.
  - Port 1 is the data/load-store or debug-loader path.
- Sequences every RAM access and applies round-robin fairness.
- Returns read data with a one-cycle ack/rvalid pulse, so requesters no longer drive ram_cs/ram_we/ram_oe directly.

---
 rtl/ram_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin front end for the CPU's single-port RAM.
// Port 0 is instruction fetch and port 1 is load/store or the debug loader.
// Every RAM cycle is sequenced here. The granted port receives a one-cycle
// ack, plus rvalid/rdata when the access is a read.
module ram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1    // cycles cs/oe are held before rdata is valid, must be >= 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_m0_req,
   input  logic              i_m0_we,
   input  logic [ADDR_W-1:0] i_m0_addr,
   input  logic [DATA_W-1:0] i_m0_wdata,
   output logic              o_m0_ack,
   output logic              o_m0_rvalid,
   output logic [DATA_W-1:0] o_m0_rdata,
   input  logic              i_m1_req,
   input  logic              i_m1_we,
   input  logic [ADDR_W-1:0] i_m1_addr,
   input  logic [DATA_W-1:0] i_m1_wdata,
   output logic              o_m1_ack,
   output logic              o_m1_rvalid,
   output logic [DATA_W-1:0] o_m1_rdata,
   output logic              o_ram_cs,
   output logic              o_ram_we,
   output logic              o_ram_oe,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   localparam int              CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_RD = CNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           r_state;
   logic             r_ptr;     // port that wins the next tie
   logic             r_gnt;     // port owning the current transaction
   logic             r_we;
   logic [CNT_W-1:0] r_cnt;

   logic              w_any;
   logic              w_gnt;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   // Arbitration: a lone requester wins outright, and a tie goes to r_ptr
   always_comb begin
      w_any       = i_m0_req | i_m1_req;
      w_gnt       = (i_m0_req & i_m1_req) ? r_ptr : i_m1_req;
      w_sel_we    = w_gnt ? i_m1_we    : i_m0_we;
      w_sel_addr  = w_gnt ? i_m1_addr  : i_m0_addr;
      w_sel_wdata = w_gnt ? i_m1_wdata : i_m0_wdata;
   end

   // Access sequencer. The RAM outputs also act as the latched addr/wdata
   // and stay frozen for the whole ACCESS state. Read data is loaded directly
   // into the owning port's rdata register on the final ACCESS edge, so the
   // other port's rdata holds its old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= 1'b0;
         r_gnt       <= 1'b0;
         r_we        <= 1'b0;
         r_cnt       <= '0;
         o_m0_ack    <= 1'b0;
         o_m0_rvalid <= 1'b0;
         o_m0_rdata  <= '0;
         o_m1_ack    <= 1'b0;
         o_m1_rvalid <= 1'b0;
         o_m1_rdata  <= '0;
         o_ram_cs    <= 1'b0;
         o_ram_we    <= 1'b0;
         o_ram_oe    <= 1'b0;
         o_ram_addr  <= '0;
         o_ram_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt       <= w_gnt;
                  r_ptr       <= ~w_gnt;
                  r_we        <= w_sel_we;
                  r_cnt       <= w_sel_we ? '0 : CNT_RD;
                  o_ram_cs    <= 1'b1;
                  o_ram_we    <= w_sel_we;
                  o_ram_oe    <= ~w_sel_we;
                  o_ram_addr  <= w_sel_addr;
                  o_ram_wdata <= w_sel_wdata;
                  r_state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (r_cnt == '0) begin
                  o_ram_cs    <= 1'b0;
                  o_ram_we    <= 1'b0;
                  o_ram_oe    <= 1'b0;
                  o_ram_addr  <= '0;
                  o_ram_wdata <= '0;
                  if (!r_gnt) begin
                     o_m0_ack    <= 1'b1;
                     o_m0_rvalid <= ~r_we;
                     if (!r_we) o_m0_rdata <= i_ram_rdata;
                  end else begin
                     o_m1_ack    <= 1'b1;
                     o_m1_rvalid <= ~r_we;
                     if (!r_we) o_m1_rdata <= i_ram_rdata;
                  end
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               o_m0_ack    <= 1'b0;
               o_m0_rvalid <= 1'b0;
               o_m1_ack    <= 1'b0;
               o_m1_rvalid <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: an RD_LAT=1 instance backed by a small RAM model, and
// an RD_LAT=3 instance fed with a per-cycle changing read bus.
module tb_ram_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- RD_LAT=1 instance ----------------
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_ack, m0_rvalid, m1_ack, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_cs, ram_we, ram_oe;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;

   ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
      .o_m0_ack(m0_ack), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
      .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
      .o_m1_ack(m1_ack), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
      .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_oe(ram_oe),
      .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
   );

   // RAM model: preloaded on the first clock, written on cs&we
   logic [31:0] mem [0:255];
   bit          mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h10] <= 32'hDEADBEEF;
         mem_ready  <= 1'b1;
      end else if (ram_cs && ram_we) begin
         mem[ram_addr[7:0]] <= ram_wdata;
      end
   end
   assign ram_rdata = (ram_cs && ram_oe) ? mem[ram_addr[7:0]] : 32'h0;

   // ---------------- RD_LAT=3 instance ----------------
   logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
   logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
   logic        b_m0_ack, b_m0_rvalid, b_m1_ack, b_m1_rvalid;
   logic [31:0] b_m0_rdata, b_m1_rdata;
   logic        b_cs, b_we, b_oe;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic [31:0] b_cyc = 32'h0;

   ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .i_m0_req(b_m0_req), .i_m0_we(b_m0_we), .i_m0_addr(b_m0_addr), .i_m0_wdata(b_m0_wdata),
      .o_m0_ack(b_m0_ack), .o_m0_rvalid(b_m0_rvalid), .o_m0_rdata(b_m0_rdata),
      .i_m1_req(b_m1_req), .i_m1_we(b_m1_we), .i_m1_addr(b_m1_addr), .i_m1_wdata(b_m1_wdata),
      .o_m1_ack(b_m1_ack), .o_m1_rvalid(b_m1_rvalid), .o_m1_rdata(b_m1_rdata),
      .o_ram_cs(b_cs), .o_ram_we(b_we), .o_ram_oe(b_oe),
      .o_ram_addr(b_addr), .o_ram_wdata(b_wdata), .i_ram_rdata(b_rdata)
   );

   // Read bus whose value changes every cycle, so the captured cycle is visible
   always @(posedge clk) b_cyc <= b_cyc + 32'h1;
   assign b_rdata = 32'hA5000000 | b_cyc;

   // ---------------- checking ----------------
   typedef struct {
      bit          p;
      bit          rv;
      logic [31:0] data;
   } exp_t;
   exp_t        sb[$];
   logic [31:0] last_rd [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
      end
   endtask

   // Writes expect the port's previous read data to be held
   task automatic push_exp(input bit p, input bit we, input logic [31:0] exp);
      if (!we) last_rd[p] = exp;
      sb.push_back('{p, !we, last_rd[p]});
   endtask

   // Scoreboard and exclusivity monitor for the RD_LAT=1 instance
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (ram_cs || ram_we || ram_oe) begin
            chk("we_oe_excl", {31'h0, ram_we & ram_oe}, 32'h0);
            chk("ctl_wo_cs", {31'h0, (ram_we | ram_oe) & ~ram_cs}, 32'h0);
         end
         if (m0_ack || m1_ack || m0_rvalid || m1_rvalid) begin
            chk("ack_excl", {31'h0, m0_ack ^ m1_ack}, 32'h1);
            if (sb.size() == 0) begin
               chk("unexpected_ack", {30'h0, m1_ack, m0_ack}, 32'h0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("ack_port", {31'h0, m1_ack}, {31'h0, e.p});
               if (e.p) begin
                  chk("m1_rvalid", {31'h0, m1_rvalid}, {31'h0, e.rv});
                  chk("m0_rvalid_idle", {31'h0, m0_rvalid}, 32'h0);
                  chk("m1_rdata", m1_rdata, e.data);
               end else begin
                  chk("m0_rvalid", {31'h0, m0_rvalid}, {31'h0, e.rv});
                  chk("m1_rvalid_idle", {31'h0, m1_rvalid}, 32'h0);
                  chk("m0_rdata", m0_rdata, e.data);
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
      b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One isolated transaction with latency and RAM-side checks
   task automatic do_req(input bit p, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
      int  n;
      int  ncs;
      bit  done;
      n = 0; ncs = 0; done = 0;
      @(posedge clk); #1;
      if (p) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
      else   begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
      push_exp(p, we, exp);
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (ram_cs) begin
            ncs++;
            chk("ram_we", {31'h0, ram_we}, {31'h0, we});
            chk("ram_oe", {31'h0, ram_oe}, {31'h0, !we});
            chk("ram_addr", ram_addr, a);
            if (we) chk("ram_wdata", ram_wdata, d);
         end
         if ((p ? m1_ack : m0_ack) === 1'b1) done = 1;
      end
      chk("ack_latency", n, 2);
      chk("cs_cycles", ncs, 1);
      m0_req = 0;
      m1_req = 0;
   endtask

   // Wait until each port has collected its target number of acks, dropping
   // a port's req right after its last ack
   task automatic wait_acks(input int t0, input int t1);
      int n0, n1, cyc;
      n0 = 0; n1 = 0; cyc = 0;
      while ((n0 < t0 || n1 < t1) && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (m0_ack === 1'b1) begin n0++; if (n0 >= t0) m0_req = 0; end
         if (m1_ack === 1'b1) begin n1++; if (n1 >= t1) m1_req = 0; end
      end
      chk("acks_m0", n0, t0);
      chk("acks_m1", n1, t1);
      m0_req = 0;
      m1_req = 0;
   endtask

   typedef struct {
      bit          p;
      bit          we;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [8];

   initial begin
      tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
      tbl[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678};
      tbl[3] = '{1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 32'h0};
      tbl[4] = '{1'b1, 1'b0, 32'h30, 32'h0,        32'hCAFEF00D};
      tbl[5] = '{1'b0, 1'b0, 32'h44, 32'h0,        32'h0};
      tbl[6] = '{1'b0, 1'b1, 32'h10, 32'h0BADF00D, 32'h0};
      tbl[7] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'h0BADF00D};

      do_reset();
      #1;
      chk("rst_ram_ctl", {29'h0, ram_cs, ram_we, ram_oe}, 32'h0);
      chk("rst_ram_addr", ram_addr, 32'h0);
      chk("rst_ram_wdata", ram_wdata, 32'h0);
      chk("rst_acks", {28'h0, m0_ack, m0_rvalid, m1_ack, m1_rvalid}, 32'h0);
      chk("rst_m0_rdata", m0_rdata, 32'h0);
      chk("rst_m1_rdata", m1_rdata, 32'h0);

      // Table-driven isolated transactions
      for (int i = 0; i < 8; i++) begin
         do_req(tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].exp);
         if (i == 0) chk("m1_quiet", {m1_ack, m1_rvalid, m1_rdata[29:0]}, 32'h0);
      end
      repeat (3) @(posedge clk);
      chk("sb_empty_tbl", sb.size(), 0);

      // Contention right after reset: m0, m1, m0, m1
      do_reset();
      @(posedge clk); #1;
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      m1_req = 1; m1_we = 0; m1_addr = 32'h30;
      push_exp(0, 0, 32'h0BADF00D);
      push_exp(1, 0, 32'hCAFEF00D);
      push_exp(0, 0, 32'h0BADF00D);
      push_exp(1, 0, 32'hCAFEF00D);
      wait_acks(2, 2);
      repeat (3) @(posedge clk);
      chk("sb_empty_cont", sb.size(), 0);

      // Late request: m1 arrives while m0 is in ACCESS
      begin
         int cyc, e0, e1;
         bit addr_ok;
         cyc = 0; e0 = -1; e1 = -1; addr_ok = 1'b0;
         @(posedge clk); #1;
         m0_req = 1; m0_we = 0; m0_addr = 32'h20;
         push_exp(0, 0, 32'h12345678);
         @(posedge clk); #1;
         chk("late_m0_cs", {31'h0, ram_cs}, 32'h1);
         m1_req = 1; m1_we = 0; m1_addr = 32'h44;
         push_exp(1, 0, 32'h0);
         while (e1 < 0 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (m0_ack === 1'b1) begin e0 = cyc; m0_req = 0; end
            if (ram_cs === 1'b1 && e0 >= 0) addr_ok = (ram_addr == 32'h44);
            if (m1_ack === 1'b1) begin e1 = cyc; m1_req = 0; end
         end
         chk("late_m0_ack", e0, 1);
         chk("late_gap", e1 - e0, 3);
         chk("late_m1_addr", {31'h0, addr_ok}, 32'h1);
      end
      repeat (2) @(posedge clk);

      // RD_LAT=3: cs/oe held 3 cycles, value of the 3rd cycle returned
      begin
         int n, ncs;
         logic [31:0] v3;
         n = 0; ncs = 0; v3 = 32'h0;
         @(posedge clk); #1;
         b_m1_req = 1; b_m1_we = 0; b_m1_addr = 32'h30;
         while (b_m1_ack !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (b_cs && b_oe) begin
               ncs++;
               if (ncs == 3) v3 = b_rdata;
               chk("l3_addr", b_addr, 32'h30);
            end
         end
         chk("l3_latency", n, 4);
         chk("l3_cs_cycles", ncs, 3);
         chk("l3_rvalid", {31'h0, b_m1_rvalid}, 32'h1);
         chk("l3_rdata", b_m1_rdata, v3);
         chk("l3_m0_quiet", {30'h0, b_m0_ack, b_m0_rvalid}, 32'h0);
         b_m1_req = 0;
         // Write on the RD_LAT=3 instance completes in one ACCESS cycle
         repeat (2) @(posedge clk); #1;
         n = 0;
         b_m0_req = 1; b_m0_we = 1; b_m0_addr = 32'h8; b_m0_wdata = 32'h55AA55AA;
         while (b_m0_ack !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         chk("l3_wr_latency", n, 2);
         chk("l3_wr_rvalid", {31'h0, b_m0_rvalid}, 32'h0);
         b_m0_req = 0;
      end

      // Reset in the middle of a read
      @(posedge clk); #1;
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      @(posedge clk); #1;
      chk("mid_cs_before", {31'h0, ram_cs}, 32'h1);
      rst_n = 1'b0;
      m0_req = 0;
      #1;
      chk("mid_ram_ctl", {29'h0, ram_cs, ram_we, ram_oe}, 32'h0);
      chk("mid_ram_addr", ram_addr, 32'h0);
      chk("mid_acks", {28'h0, m0_ack, m0_rvalid, m1_ack, m1_rvalid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      sb.delete();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("no_stale_ack", {30'h0, m0_ack, m1_ack}, 32'h0);
      end
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      m1_req = 1; m1_we = 0; m1_addr = 32'h20;
      push_exp(0, 0, 32'h0BADF00D);
      push_exp(1, 0, 32'h12345678);
      wait_acks(1, 1);
      repeat (3) @(posedge clk);
      chk("sb_empty_end", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
